// File: rtl/bp_initiator_pkg.sv
// Shared definitions for the bytepipe initiator: command byte layout,
// burst register constants and the FSM state encoding.
package bp_initiator_pkg;

  // Bit of the command byte that selects write (1) or read (0)
  localparam int CMD_WR_BIT = 7;

  // The responder keeps its burst-length register at this address
  localparam logic [6:0] BURST_ADDR = 7'd0;

  // Command byte that writes the burst-length register
  localparam logic [7:0] BURST_SET_CMD = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    SETB,
    LEN,
    ACKB,
    CMD,
    WDAT,
    RECV
  } bpState_e;

  // Build a command byte from the write flag and the target address
  function automatic logic [7:0] makeCmd(input logic wr, input logic [6:0] addr);
    logic [7:0] cmd;
    cmd = {1'b0, addr};
    cmd[CMD_WR_BIT] = wr;
    return cmd;
  endfunction

endpackage

// File: rtl/bp_initiator_if.sv
// Request, bytepipe and response channels of the initiator. Signal names
// keep the direction prefix as seen from the initiator (master).
interface bp_initiator_if;

  logic       i_req_valid;
  logic       o_req_ready;
  logic       i_req_wr;
  logic [6:0] i_req_addr;
  logic [7:0] i_req_data;
  logic [7:0] i_req_len;

  logic [7:0] o_bp_data;
  logic       o_bp_valid;
  logic       i_bp_ready;
  logic [7:0] i_bp_data;
  logic       i_bp_valid;
  logic       o_bp_ready;

  logic [7:0] o_rsp_data;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic       o_rsp_last;

  logic       o_busy;

  modport master (
    input  i_req_valid, i_req_wr, i_req_addr, i_req_data, i_req_len,
    input  i_bp_ready, i_bp_data, i_bp_valid, i_rsp_ready,
    output o_req_ready, o_bp_data, o_bp_valid, o_bp_ready,
    output o_rsp_data, o_rsp_valid, o_rsp_last, o_busy
  );

  modport slave (
    output i_req_valid, i_req_wr, i_req_addr, i_req_data, i_req_len,
    output i_bp_ready, i_bp_data, i_bp_valid, i_rsp_ready,
    input  o_req_ready, o_bp_data, o_bp_valid, o_bp_ready,
    input  o_rsp_data, o_rsp_valid, o_rsp_last, o_busy
  );

endinterface

// File: rtl/bp_initiator.sv
// Bytepipe initiator: serialises one request into command/length/data bytes
// for a bytepipe responder and streams the response bytes back with a last
// flag. Multi-byte reads either program the responder burst register once
// (BURST_EN=1) or repeat a single-read command per byte (BURST_EN=0).
module bp_initiator
  import bp_initiator_pkg::*;
#(
  parameter bit BURST_EN = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_cg,
  bp_initiator_if.master bus
);

  bpState_e   state_q;
  logic       wr_q;
  logic [6:0] addr_q;
  logic [7:0] data_q;
  logic [7:0] len_q;
  logic [7:0] cnt_q;
  logic [7:0] reqLenEff;
  logic       rspXfer;

  // Writes and reads of the burst register always return exactly one byte
  always_comb begin
    reqLenEff = (bus.i_req_wr || (bus.i_req_addr == BURST_ADDR)) ? 8'd0 : bus.i_req_len;
  end

  // A response byte is consumed only when the user takes it
  always_comb begin
    rspXfer = bus.i_bp_valid && bus.i_rsp_ready;
  end

  // Transaction FSM plus latched request; everything freezes while i_cg is low
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 7'd0;
      data_q  <= 8'd0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
    end else if (i_cg) begin
      case (state_q)
        IDLE: begin
          if (bus.i_req_valid) begin
            wr_q   <= bus.i_req_wr;
            addr_q <= bus.i_req_addr;
            data_q <= bus.i_req_data;
            len_q  <= reqLenEff;
            cnt_q  <= reqLenEff;
            if (!bus.i_req_wr && BURST_EN && (reqLenEff != 8'd0)) begin
              state_q <= SETB;
            end else begin
              state_q <= CMD;
            end
          end
        end
        SETB: if (bus.i_bp_ready) state_q <= LEN;
        LEN:  if (bus.i_bp_ready) state_q <= ACKB;
        ACKB: if (bus.i_bp_valid) state_q <= CMD;
        CMD: begin
          if (bus.i_bp_ready) begin
            state_q <= wr_q ? WDAT : RECV;
          end
        end
        WDAT: if (bus.i_bp_ready) state_q <= RECV;
        RECV: begin
          if (rspXfer) begin
            if (cnt_q == 8'd0) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_q - 8'd1;
              state_q <= (BURST_EN || wr_q) ? RECV : CMD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus outputs are decoded from the state and the latched request only;
  // the response path in RECV is a straight pass-through so the user owns
  // backpressure. Ready for a new request is withheld while reset is active.
  always_comb begin
    bus.o_req_ready = 1'b0;
    bus.o_bp_data   = 8'd0;
    bus.o_bp_valid  = 1'b0;
    bus.o_bp_ready  = 1'b0;
    bus.o_rsp_data  = 8'd0;
    bus.o_rsp_valid = 1'b0;
    bus.o_rsp_last  = 1'b0;
    bus.o_busy      = (state_q != IDLE);
    case (state_q)
      IDLE: bus.o_req_ready = !i_rst;
      SETB: begin
        bus.o_bp_valid = 1'b1;
        bus.o_bp_data  = BURST_SET_CMD;
      end
      LEN: begin
        bus.o_bp_valid = 1'b1;
        bus.o_bp_data  = len_q;
      end
      ACKB: bus.o_bp_ready = 1'b1;
      CMD: begin
        bus.o_bp_valid = 1'b1;
        bus.o_bp_data  = makeCmd(wr_q, addr_q);
      end
      WDAT: begin
        bus.o_bp_valid = 1'b1;
        bus.o_bp_data  = data_q;
      end
      RECV: begin
        bus.o_rsp_data  = bus.i_bp_data;
        bus.o_rsp_valid = bus.i_bp_valid;
        bus.o_bp_ready  = bus.i_rsp_ready;
        bus.o_rsp_last  = bus.i_bp_valid && (cnt_q == 8'd0);
      end
      default: bus.o_busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_bp_initiator.sv
// Self-checking bench for bp_initiator: one instance with burst reads and one
// issuing repeated single reads, each paired with a queue-driven responder and
// a scoreboard of expected bus bytes and response beats.
module tb_bp_initiator;

  logic clk = 1'b0;
  logic rst;
  logic cg;
  int   checks = 0;
  int   errors = 0;

  bp_initiator_if bus0 ();
  bp_initiator_if bus1 ();

  bp_initiator #(.BURST_EN(1'b1)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .i_cg  (cg),
    .bus   (bus0)
  );

  bp_initiator #(.BURST_EN(1'b0)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .i_cg  (cg),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  // Responder byte queues and scoreboards ({last, data} for responses)
  logic [7:0] respQ0[$];
  logic [7:0] respQ1[$];
  logic [7:0] expBp0[$];
  logic [7:0] expBp1[$];
  logic [8:0] expRsp0[$];
  logic [8:0] expRsp1[$];
  logic       xfer0 = 1'b0;
  logic       xfer1 = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outVec(input int d);
    if (d == 0)
      return {10'd0, bus0.o_req_ready, bus0.o_busy, bus0.o_rsp_last, bus0.o_rsp_valid,
              bus0.o_bp_ready, bus0.o_bp_valid, bus0.o_bp_data, bus0.o_rsp_data};
    return {10'd0, bus1.o_req_ready, bus1.o_busy, bus1.o_rsp_last, bus1.o_rsp_valid,
            bus1.o_bp_ready, bus1.o_bp_valid, bus1.o_bp_data, bus1.o_rsp_data};
  endfunction

  // Observe bus and response transfers away from the active edge
  always @(negedge clk) begin
    xfer0 = !rst && cg && bus0.o_bp_ready && bus0.i_bp_valid;
    xfer1 = !rst && cg && bus1.o_bp_ready && bus1.i_bp_valid;
    if (!rst && cg) begin
      if (bus0.o_bp_valid && bus0.i_bp_ready) begin
        if (expBp0.size() == 0) checkOutput("dut0 unexpected bp byte", {24'd0, bus0.o_bp_data}, 32'hFFFF_FFFF);
        else checkOutput("dut0 bp byte", {24'd0, bus0.o_bp_data}, {24'd0, expBp0.pop_front()});
      end
      if (bus0.o_rsp_valid && bus0.i_rsp_ready) begin
        if (expRsp0.size() == 0) checkOutput("dut0 unexpected rsp", {23'd0, bus0.o_rsp_last, bus0.o_rsp_data}, 32'hFFFF_FFFF);
        else checkOutput("dut0 rsp {last,data}", {23'd0, bus0.o_rsp_last, bus0.o_rsp_data}, {23'd0, expRsp0.pop_front()});
      end
      if (bus1.o_bp_valid && bus1.i_bp_ready) begin
        if (expBp1.size() == 0) checkOutput("dut1 unexpected bp byte", {24'd0, bus1.o_bp_data}, 32'hFFFF_FFFF);
        else checkOutput("dut1 bp byte", {24'd0, bus1.o_bp_data}, {24'd0, expBp1.pop_front()});
      end
      if (bus1.o_rsp_valid && bus1.i_rsp_ready) begin
        if (expRsp1.size() == 0) checkOutput("dut1 unexpected rsp", {23'd0, bus1.o_rsp_last, bus1.o_rsp_data}, 32'hFFFF_FFFF);
        else checkOutput("dut1 rsp {last,data}", {23'd0, bus1.o_rsp_last, bus1.o_rsp_data}, {23'd0, expRsp1.pop_front()});
      end
    end
  end

  // Responder models: present the head of the queue, pop on a transfer
  always @(posedge clk) begin
    #1;
    if (xfer0 && respQ0.size() != 0) void'(respQ0.pop_front());
    if (xfer1 && respQ1.size() != 0) void'(respQ1.pop_front());
    bus0.i_bp_valid = (respQ0.size() != 0);
    bus0.i_bp_data  = (respQ0.size() != 0) ? respQ0[0] : 8'h00;
    bus1.i_bp_valid = (respQ1.size() != 0);
    bus1.i_bp_data  = (respQ1.size() != 0) ? respQ1[0] : 8'h00;
  end

  // Reference model of one transaction: fills responder and scoreboard queues
  task automatic pushTxn(input int d, input bit wr, input logic [6:0] addr,
                         input logic [7:0] data, input logic [7:0] len, input logic [7:0] base);
    logic [7:0] bp[$];
    logic [7:0] rs[$];
    logic [8:0] ex[$];
    logic [7:0] effLen;
    bit         burstEn;
    int         n;
    burstEn = (d == 0);
    effLen  = (wr || addr == 7'd0) ? 8'd0 : len;
    n       = int'(effLen) + 1;
    if (wr) begin
      bp.push_back({1'b1, addr});
      bp.push_back(data);
      rs.push_back(base);
      ex.push_back({1'b1, base});
    end else begin
      if (burstEn && effLen != 8'd0) begin
        bp.push_back(8'h80);
        bp.push_back(effLen);
        rs.push_back(8'hEE);
      end
      for (int i = 0; i < n; i++) begin
        if (!burstEn || i == 0) bp.push_back({1'b0, addr});
        rs.push_back(base + 8'(i));
        ex.push_back({(i == n - 1), base + 8'(i)});
      end
    end
    if (d == 0) begin
      foreach (bp[i]) expBp0.push_back(bp[i]);
      foreach (rs[i]) respQ0.push_back(rs[i]);
      foreach (ex[i]) expRsp0.push_back(ex[i]);
    end else begin
      foreach (bp[i]) expBp1.push_back(bp[i]);
      foreach (rs[i]) respQ1.push_back(rs[i]);
      foreach (ex[i]) expRsp1.push_back(ex[i]);
    end
  endtask

  task automatic driveReq(input int d, input logic v, input logic wr, input logic [6:0] addr,
                          input logic [7:0] data, input logic [7:0] len);
    if (d == 0) begin
      bus0.i_req_valid = v; bus0.i_req_wr = wr; bus0.i_req_addr = addr;
      bus0.i_req_data  = data; bus0.i_req_len = len;
    end else begin
      bus1.i_req_valid = v; bus1.i_req_wr = wr; bus1.i_req_addr = addr;
      bus1.i_req_data  = data; bus1.i_req_len = len;
    end
  endtask

  // Issue one request; returns 1 time unit after the accepting edge
  task automatic applyStimulus(input int d, input bit wr, input logic [6:0] addr,
                               input logic [7:0] data, input logic [7:0] len, input logic [7:0] base);
    logic [31:0] v;
    bit accepted;
    pushTxn(d, wr, addr, data, len, base);
    driveReq(d, 1'b1, wr, addr, data, len);
    accepted = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      v = outVec(d);
      if (v[21] && cg) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    driveReq(d, 1'b0, 1'b0, 7'd0, 8'd0, 8'd0);
    if (!accepted) begin
      checkOutput("request accept timeout", 32'd0, 32'd1);
    end else begin
      v = outVec(d);
      checkOutput("first bp_valid one cycle after accept", {31'd0, v[16]}, 32'd1);
    end
  endtask

  // Wait for the transaction to drain; then the initiator must be ready again
  task automatic waitIdle(input int d, input int limit);
    logic [31:0] v;
    bit done;
    done = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      #1;
      v = outVec(d);
      if (d == 0) done = (expBp0.size() == 0) && (expRsp0.size() == 0) && !v[20];
      else        done = (expBp1.size() == 0) && (expRsp1.size() == 0) && !v[20];
      if (done) break;
    end
    checkOutput("transaction completes in budget", {31'd0, done}, 32'd1);
    v = outVec(d);
    checkOutput("req_ready after last response", {31'd0, v[21]}, 32'd1);
  endtask

  initial begin
    logic [31:0] v;
    bit reached;
    rst = 1'b1;
    cg  = 1'b1;
    driveReq(0, 1'b0, 1'b0, 7'd0, 8'd0, 8'd0);
    driveReq(1, 1'b0, 1'b0, 7'd0, 8'd0, 8'd0);
    bus0.i_bp_ready = 1'b1; bus0.i_rsp_ready = 1'b1;
    bus1.i_bp_ready = 1'b1; bus1.i_rsp_ready = 1'b1;
    bus0.i_bp_valid = 1'b0; bus0.i_bp_data = 8'h00;
    bus1.i_bp_valid = 1'b0; bus1.i_bp_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("dut0 reset values", outVec(0), 32'h0020_0000);
    checkOutput("dut1 reset values", outVec(1), 32'h0020_0000);
    @(posedge clk);
    #1;

    $display("[TB] single read addr 0x10");
    applyStimulus(0, 1'b0, 7'h10, 8'h00, 8'd0, 8'hA5);
    waitIdle(0, 100);

    $display("[TB] single write addr 0x01 data 0x3C");
    applyStimulus(0, 1'b1, 7'h01, 8'h3C, 8'd9, 8'h5A);
    waitIdle(0, 100);

    $display("[TB] burst read addr 0x02 len 3");
    applyStimulus(0, 1'b0, 7'h02, 8'h00, 8'd3, 8'h11);
    waitIdle(0, 100);

    $display("[TB] repeated single reads addr 0x02 len 3");
    applyStimulus(1, 1'b0, 7'h02, 8'h00, 8'd3, 8'h21);
    waitIdle(1, 100);

    $display("[TB] bp_ready stall during LEN");
    bus0.i_bp_ready = 1'b0;
    applyStimulus(0, 1'b0, 7'h02, 8'h00, 8'd3, 8'h60);
    bus0.i_bp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus0.i_bp_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("LEN byte held while stalled", {23'd0, bus0.o_bp_valid, bus0.o_bp_data}, 32'h0000_0103);
    end
    @(posedge clk);
    #1;
    bus0.i_bp_ready = 1'b1;
    waitIdle(0, 100);

    $display("[TB] clock gate hold in CMD");
    applyStimulus(0, 1'b0, 7'h05, 8'h00, 8'd0, 8'h77);
    cg = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("CMD byte held with cg low", {23'd0, bus0.o_bp_valid, bus0.o_bp_data}, 32'h0000_0105);
    end
    @(posedge clk);
    #1;
    cg = 1'b1;
    waitIdle(0, 100);

    $display("[TB] len 255 burst");
    applyStimulus(0, 1'b0, 7'h03, 8'h00, 8'd255, 8'h00);
    waitIdle(0, 600);

    $display("[TB] reset in RECV with cnt 2");
    applyStimulus(0, 1'b0, 7'h02, 8'h00, 8'd3, 8'h40);
    reached = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (expRsp0.size() == 3) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("reached RECV after first response", {31'd0, reached}, 32'd1);
    bus0.i_rsp_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("outputs cleared by async reset", outVec(0), 32'h0000_0000);
    respQ0.delete();
    expBp0.delete();
    expRsp0.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus0.i_rsp_ready = 1'b1;
    #1;
    v = outVec(0);
    checkOutput("req_ready after reset release", {31'd0, v[21]}, 32'd1);
    checkOutput("busy low after reset release", {31'd0, v[20]}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] read addr 0x00 len 7 returns one byte");
    applyStimulus(0, 1'b0, 7'h00, 8'h00, 8'd7, 8'h00);
    waitIdle(0, 100);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
